bit_packer: RTL and testbench

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer.sv | 87 ++++++++
 tb/tb_bit_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// Serial-to-parallel bit packer: MSB-first capture of WIDTH-bit words into a
// DEPTH-entry output FIFO with sticky overrun flag and saturating drop counter.
module bit_packer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     ck,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     din,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overrun,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

   // Only the low WIDTH-1 bits of the shift register ever reach a completed word.
   logic [WIDTH-2:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [WIDTH-1:0] word;
   logic             push;
   logic             pop;
   logic             full;
   logic             accept;

   always_comb begin
      word   = {shreg, din};
      push   = en & (bit_cnt == LAST);
      pop    = out_valid & out_ready;
      full   = (level == FULL);
      accept = push & (~full | pop);
   end

   assign out_valid = (level != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge ck) begin
      if (accept && !rst) begin
         mem[wr_ptr] <= word;
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (en) begin
            shreg   <= word[WIDTH-2:0];
            bit_cnt <= push ? '0 : bit_cnt + CW'(1);
         end
         if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({accept, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
         if (push && full && !pop) begin
            overrun <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_bit_packer;

   localparam int W = 8;
   localparam int D = 4;

   logic         ck = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         din = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic [2:0]   level;
   logic         overrun;
   logic [7:0]   drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   bit_packer #(.WIDTH(W), .DEPTH(D)) dut (
      .ck(ck), .rst(rst), .en(en), .din(din),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .overrun(overrun), .drop_cnt(drop_cnt)
   );

   always #5 ck = ~ck;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words as a queue, partial word as an integer accumulator.
   logic [W-1:0] m_q[$];
   int           m_bits  = 0;
   int           m_acc   = 0;
   int           m_ovr   = 0;
   int           m_drops = 0;
   bit           armed   = 1'b0;

   always @(posedge ck) begin
      int  pre;
      bit  do_pop;
      bit  done;
      if (rst) begin
         m_q.delete();
         m_bits  = 0;
         m_acc   = 0;
         m_ovr   = 0;
         m_drops = 0;
         armed   = 1'b1;
      end else begin
         pre    = m_q.size();
         do_pop = (pre != 0) && out_ready;
         done   = 1'b0;
         if (en) begin
            m_acc = ((m_acc * 2) + int'(din)) % 256;
            m_bits++;
            if (m_bits == W) begin
               done   = 1'b1;
               m_bits = 0;
            end
         end
         if (do_pop) void'(m_q.pop_front());
         if (done) begin
            if (pre < D || do_pop) m_q.push_back(W'(m_acc));
            else begin
               m_ovr = 1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
   end

   always @(negedge ck) begin
      if (armed) begin
         cmp("model_level", int'(level), m_q.size());
         cmp("model_valid", int'(out_valid), int'(m_q.size() != 0));
         if (m_q.size() != 0) cmp("model_data", int'(out_data), int'(m_q[0]));
         cmp("model_overrun", int'(overrun), m_ovr);
         cmp("model_drop_cnt", int'(drop_cnt), m_drops);
      end
   end

   task automatic step(input logic r, input logic e, input logic d, input logic rdy);
      @(negedge ck);
      rst = r; en = e; din = d; out_ready = rdy;
      @(posedge ck);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
      for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, w[i], (i == 0) ? rdy_last : 1'b0);
   endtask

   task automatic pop_expect(input string name, input logic [W-1:0] exp);
      cmp(name, int'(out_data), int'(exp));
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] seq_a;
      logic [7:0] seq_b;
      int         rdy_pct;

      // Reset state
      step(1'b1, 1'b1, 1'b1, 1'b1);
      cmp("reset_level", int'(level), 0);
      cmp("reset_valid", int'(out_valid), 0);
      cmp("reset_data", int'(out_data), 0);
      cmp("reset_overrun", int'(overrun), 0);
      cmp("reset_drop_cnt", int'(drop_cnt), 0);

      // Basic packing 1,0,1,1,0,0,1,0
      seq_a = 8'b1011_0010;
      for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, seq_a[i], 1'b0);
      cmp("basic_data", int'(out_data), 'hB2);
      cmp("basic_valid", int'(out_valid), 1);
      cmp("basic_level", int'(level), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      cmp("basic_pop_level", int'(level), 0);

      // Enable gap keeps the partial word
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'(i), 1'b0);
      cmp("gap_no_word", int'(out_valid), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      cmp("gap_data", int'(out_data), 'hF0);
      cmp("gap_level", int'(level), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Fill and overrun
      for (int i = 1; i <= 5; i++) send_word(8'(i), 1'b0);
      cmp("fill_level", int'(level), 4);
      cmp("fill_overrun", int'(overrun), 1);
      cmp("fill_drop_cnt", int'(drop_cnt), 1);
      pop_expect("fill_pop0", 8'h01);
      pop_expect("fill_pop1", 8'h02);
      pop_expect("fill_pop2", 8'h03);
      pop_expect("fill_pop3", 8'h04);
      cmp("fill_empty", int'(out_valid), 0);
      cmp("sticky_overrun", int'(overrun), 1);

      // Simultaneous push and pop while full
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      send_word(8'h33, 1'b0);
      send_word(8'h44, 1'b0);
      send_word(8'hAA, 1'b1);
      cmp("full_pp_level", int'(level), 4);
      cmp("full_pp_overrun", int'(overrun), 0);
      pop_expect("full_pp_pop0", 8'h22);
      pop_expect("full_pp_pop1", 8'h33);
      pop_expect("full_pp_pop2", 8'h44);
      pop_expect("full_pp_pop3", 8'hAA);

      // Reset mid-operation
      send_word(8'hC3, 1'b0);
      send_word(8'h3C, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      cmp("midrst_pre_level", int'(level), 2);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      cmp("midrst_level", int'(level), 0);
      cmp("midrst_valid", int'(out_valid), 0);
      cmp("midrst_overrun", int'(overrun), 0);
      seq_b = 8'h5A;
      for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, seq_b[i], 1'b0);
      cmp("midrst_data", int'(out_data), 'h5A);
      cmp("midrst_level1", int'(level), 1);

      // drop_cnt saturation
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < D; i++) send_word(8'(i + 8'h40), 1'b0);
      for (int i = 0; i < 260; i++) send_word(8'(i), 1'b0);
      cmp("sat_drop_cnt", int'(drop_cnt), 255);
      cmp("sat_overrun", int'(overrun), 1);
      cmp("sat_level", int'(level), 4);
      pop_expect("sat_head", 8'h40);

      // Randomized traffic with varying consumer rate
      for (int seg = 0; seg < 6; seg++) begin
         rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 95);
         for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < rdy_pct));
         end
      end

      @(negedge ck);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
